adc_spi_master: RTL and testbench



---
 rtl/adc_pkg.sv | 9 +
 rtl/sample_rate_tick.sv | 14 +
 rtl/adc_spi_master.sv | 89 ++++++++
 tb/tb_adc_spi_master.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM encoding and frame constants for the ADC serial link.
package adc_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GUARD} state_t;
  localparam int N_SCLK = 16;
  localparam int ADC_BITS = 12;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/sample_rate_tick.sv
// sample_rate_tick: free-running 0..PERIOD-1 counter with a tick on the last count.
module sample_rate_tick #(
  parameter int PERIOD = 2268
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = PERIOD > 1 ? $clog2(PERIOD) : 1;
  logic [W-1:0] count;
  assign tick = count == W'(PERIOD - 1);
  always_ff @(posedge clk)
    count <= (rst || tick) ? '0 : count + W'(1);
endmodule

// File: rtl/adc_spi_master.sv
// adc_spi_master: cs/sclk/rx_en timing generator launching one 16-clock frame per sample period.
module adc_spi_master
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int CS_SETUP    = 4,
  parameter int PERIOD      = 2268,
  parameter int CS_HIGH_MIN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic cs,
  output logic sclk,
  output logic rx_en,
  output logic frame_start_tick,
  output logic frame_end_tick,
  output logic busy,
  output logic missed_tick
);
  localparam int PMAX = max3(CS_SETUP, CLK_DIV, CS_HIGH_MIN);
  localparam int PW = PMAX > 1 ? $clog2(PMAX) : 1;
  state_t state;
  logic [PW-1:0] phase;
  logic [4:0] edges;
  logic tick;
  sample_rate_tick #(.PERIOD(PERIOD)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cs <= 1'b1;
      sclk <= 1'b1;
      busy <= 1'b0;
      rx_en <= 1'b0;
      frame_start_tick <= 1'b0;
      frame_end_tick <= 1'b0;
      missed_tick <= 1'b0;
      phase <= '0;
      edges <= '0;
    end else begin
      rx_en <= en;
      frame_start_tick <= 1'b0;
      frame_end_tick <= 1'b0;
      missed_tick <= tick && state != IDLE;
      case (state)
        IDLE:
          if (tick && en) begin
            state <= SETUP;
            cs <= 1'b0;
            busy <= 1'b1;
            frame_start_tick <= 1'b1;
            phase <= '0;
          end
        SETUP:
          if (phase == PW'(CS_SETUP - 1)) begin
            state <= SHIFT;
            sclk <= 1'b0;
            edges <= 5'd1;
            phase <= '0;
          end else phase <= phase + PW'(1);
        // edges counts falling edges; the frame ends after the high phase following the last fall
        SHIFT:
          if (phase == PW'(CLK_DIV - 1)) begin
            phase <= '0;
            if (!sclk) sclk <= 1'b1;
            else if (edges == 5'(N_SCLK)) state <= HOLD;
            else begin
              sclk <= 1'b0;
              edges <= edges + 5'd1;
            end
          end else phase <= phase + PW'(1);
        HOLD:
          if (phase == PW'(CLK_DIV - 1)) begin
            state <= GUARD;
            cs <= 1'b1;
            busy <= 1'b0;
            frame_end_tick <= 1'b1;
            phase <= '0;
          end else phase <= phase + PW'(1);
        GUARD:
          if (phase == PW'(CS_HIGH_MIN - 1)) begin
            state <= IDLE;
            phase <= '0;
          end else phase <= phase + PW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_master.sv
// tb_adc_spi_master: directed checks of three configurations (default, fast, over-subscribed period).
module tb_adc_spi_master;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] en = 3'b111;
  logic [2:0] cs, sclk, rx_en, fst, fet, busy, miss;
  int cyc = 0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  adc_spi_master u_a (.clk(clk), .rst(rst), .en(en[0]), .cs(cs[0]), .sclk(sclk[0]), .rx_en(rx_en[0]),
    .frame_start_tick(fst[0]), .frame_end_tick(fet[0]), .busy(busy[0]), .missed_tick(miss[0]));
  adc_spi_master #(.CLK_DIV(2), .CS_SETUP(2), .PERIOD(100), .CS_HIGH_MIN(8)) u_b (.clk(clk), .rst(rst),
    .en(en[1]), .cs(cs[1]), .sclk(sclk[1]), .rx_en(rx_en[1]), .frame_start_tick(fst[1]),
    .frame_end_tick(fet[1]), .busy(busy[1]), .missed_tick(miss[1]));
  adc_spi_master #(.CLK_DIV(2), .CS_SETUP(2), .PERIOD(60), .CS_HIGH_MIN(8)) u_c (.clk(clk), .rst(rst),
    .en(en[2]), .cs(cs[2]), .sclk(sclk[2]), .rx_en(rx_en[2]), .frame_start_tick(fst[2]),
    .frame_end_tick(fet[2]), .busy(busy[2]), .missed_tick(miss[2]));

  function automatic bit legal(input int cd, input int cs_setup, input int period, input int high_min);
    return cs_setup + 33 * cd + high_min <= period;
  endfunction
  initial begin
    assert (legal(4, 4, 2268, 16));
    assert (legal(2, 2, 100, 8));
  end

  // ADC model on instance b: shifts on sclk falls, receiver samples on rises
  logic [15:0] word = 16'h0A5C;
  logic [15:0] sr = '0;
  logic sdo = 1'b0;
  int bi = 0;
  int rx_q[$];
  always @(negedge cs[1]) bi = 16;
  always @(negedge sclk[1]) if (bi > 0) begin bi--; sdo = word[bi]; end
  always @(posedge sclk[1]) sr = {sr[14:0], sdo};
  always @(posedge cs[1]) if (!rst) rx_q.push_back(int'(sr[11:0]));

  int n_fall[3], n_rise[3], n_sf[3], n_miss[3];
  int fall_at[3][64], rise_at[3][64], len_at[3][64], rises_at[3][64], sf_at[3][64], miss_at[3][64];
  int bad_fst[3], bad_fet[3], bad_busy[3], bad_sclk[3], last_fall[3], cur_rises[3];
  logic [2:0] prev_cs, prev_sclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < 3; i++) begin
      n_fall[i] = 0; n_rise[i] = 0; n_sf[i] = 0; n_miss[i] = 0;
      bad_fst[i] = 0; bad_fet[i] = 0; bad_busy[i] = 0; bad_sclk[i] = 0;
      fall_at[i][0] = -1; rise_at[i][0] = -1; len_at[i][0] = -1;
      rises_at[i][0] = -1; sf_at[i][0] = -1; miss_at[i][0] = -1;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (fst[i] != (prev_cs[i] && !cs[i])) bad_fst[i]++;
        if (fet[i] != (!prev_cs[i] && cs[i])) bad_fet[i]++;
        if (busy[i] != !cs[i]) bad_busy[i]++;
        if (cs[i] && !sclk[i]) bad_sclk[i]++;
        if (prev_cs[i] && !cs[i]) begin
          if (n_fall[i] < 64) fall_at[i][n_fall[i]] = cyc;
          n_fall[i]++; last_fall[i] = cyc; cur_rises[i] = 0;
        end
        if (!prev_sclk[i] && sclk[i]) cur_rises[i]++;
        if (prev_sclk[i] && !sclk[i]) begin
          if (n_sf[i] < 64) sf_at[i][n_sf[i]] = cyc;
          n_sf[i]++;
        end
        if (!prev_cs[i] && cs[i]) begin
          if (n_rise[i] < 64) begin
            rise_at[i][n_rise[i]] = cyc;
            len_at[i][n_rise[i]] = cyc - last_fall[i];
            rises_at[i][n_rise[i]] = cur_rises[i];
          end
          n_rise[i]++;
        end
        if (miss[i]) begin
          if (n_miss[i] < 64) miss_at[i][n_miss[i]] = cyc;
          n_miss[i]++;
        end
      end
      prev_cs = cs; prev_sclk = sclk;
    end
  endtask

  initial begin
    int bad;
    clear();
    repeat (3) @(negedge clk);
    chk("rst_cs", int'(cs[0]), 1);
    chk("rst_sclk", int'(sclk[0]), 1);
    chk("rst_rx_en", int'(rx_en[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_fst", int'(fst[0]), 0);
    chk("rst_fet", int'(fet[0]), 0);
    chk("rst_miss", int'(miss[0]), 0);
    prev_cs = cs; prev_sclk = sclk;
    rst = 1'b0;
    run(2500);
    // default configuration
    chk("a_cs_fall", fall_at[0][0], 2268);
    chk("a_sclk_falls", n_sf[0], 16);
    chk("a_sclk_first", sf_at[0][0], 2272);
    bad = 0;
    for (int j = 1; j < 16; j++) if (sf_at[0][j] - sf_at[0][j-1] != 8) bad++;
    chk("a_sclk_spacing", bad, 0);
    chk("a_cs_rise", rise_at[0][0], 2404);
    chk("a_len", len_at[0][0], 136);
    chk("a_rises", rises_at[0][0], 16);
    chk("a_fst", bad_fst[0], 0);
    chk("a_fet", bad_fet[0], 0);
    chk("a_busy", bad_busy[0], 0);
    chk("a_miss", n_miss[0], 0);
    // fast configuration
    chk("b_first", fall_at[1][0], 100);
    bad = 0;
    for (int j = 1; j < 5; j++) if (fall_at[1][j] - fall_at[1][j-1] != 100) bad++;
    for (int j = 0; j < 5; j++) if (len_at[1][j] != 68 || rises_at[1][j] != 16) bad++;
    chk("b_frames", bad, 0);
    chk("b_fst", bad_fst[1], 0);
    chk("b_busy", bad_busy[1], 0);
    chk("b_miss", n_miss[1], 0);
    chk("b_rx_count_ok", int'(rx_q.size() >= 5), 1);
    bad = 0;
    for (int j = 0; j < 5 && j < rx_q.size(); j++) if (rx_q[j] != 'hA5C) bad++;
    chk("b_rx_data", bad, 0);
    // over-subscribed period: every other tick dropped
    chk("c_starts", n_fall[2], 21);
    chk("c_missed", n_miss[2], 20);
    chk("c_miss_first", miss_at[2][0], 120);
    bad = 0;
    for (int j = 1; j < 20; j++) if (miss_at[2][j] - miss_at[2][j-1] != 120) bad++;
    for (int j = 1; j < 21; j++) if (fall_at[2][j] - fall_at[2][j-1] != 120) bad++;
    for (int j = 0; j < 20; j++) if (len_at[2][j] != 68) bad++;
    chk("c_pattern", bad, 0);
    chk("c_glitch", bad_sclk[2], 0);
    // en dropped 10 cycles into a frame on b
    run(10);
    en[1] = 1'b0;
    chk("b_rx_en_before", int'(rx_en[1]), 1);
    run(1);
    chk("b_rx_en_after", int'(rx_en[1]), 0);
    clear();
    run(300);
    chk("b_drop_rise", rise_at[1][0], 2568);
    chk("b_drop_len", len_at[1][0], 68);
    chk("b_drop_rises", rises_at[1][0], 16);
    chk("b_drop_nofall", n_fall[1], 0);
    chk("b_drop_nrise", n_rise[1], 1);
    // reset mid-SHIFT on a
    clear();
    run(1745);
    chk("a_second_fall", fall_at[0][0], 4536);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs", int'(cs[0]), 1);
    chk("mid_rst_sclk", int'(sclk[0]), 1);
    chk("mid_rst_fet", int'(fet[0]), 0);
    chk("mid_rst_busy", int'(busy[0]), 0);
    prev_cs = cs; prev_sclk = sclk;
    rst = 1'b0;
    clear();
    run(2300);
    chk("a_restart_fall", fall_at[0][0], 2268);
    chk("a_restart_fet", bad_fet[0], 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
